// File: rtl/bids_n_engine.sv
// bids_n_engine -- N-bidder auction controller with per-bidder balances.
//
// A key-protected configuration port (C_op/C_data) loads balances, the
// bidder mask, the round length and a per-bid fee. C_start opens a round.
// During the round each bidder may bid or retract. Each accepted bid pays
// the fee immediately. When the round timer expires, a one-cycle settle
// step pulses win for the leader and deducts the winning amount.
//
// Optional feature: define BIDS_ANTISNIPE_EN so that a leader change while
// timer < ANTISNIPE_WINDOW reloads the timer to ANTISNIPE_WINDOW. When the
// macro is undefined, the round always ends on schedule.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   bid_amt      per-bidder amount; bidder i occupies slice i
//   bid/retract  per-bidder request strobes
//   C_data/C_op  command operand and opcode (0..6 valid)
//   C_start      start a round; accepted only while LOCKED
//   ack          per-bidder request accepted (1-cycle pulse)
//   bid_err      per-bidder 2-bit code: 0 none, 1 round inactive,
//                2 invalid request, 3 insufficient funds
//   balance      per-bidder balances
//   win          one-hot winner pulse
//   ready        idle (LOCKED or UNLOCKED)
//   err          3-bit command code: 0 none, 1 bad key, 2 already unlocked,
//                3 start while unlocked, 4 invalid op
//   roundOver    1-cycle pulse at settlement
//   maxBid       current or final winning amount, zero-extended
// All outputs are registered and respond one cycle after the input.
module bids_n_engine #(
    parameter int DATAWIDTH        = 32,
    parameter int NUMBIDDERS       = 4,
    parameter int BIDAMTBITS       = DATAWIDTH / 2,
    parameter int ANTISNIPE_WINDOW = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUMBIDDERS*BIDAMTBITS-1:0] bid_amt,
    input  logic [NUMBIDDERS-1:0]            bid,
    input  logic [NUMBIDDERS-1:0]            retract,
    input  logic [DATAWIDTH-1:0]             C_data,
    input  logic [3:0]                       C_op,
    input  logic                             C_start,
    output logic [NUMBIDDERS-1:0]            ack,
    output logic [NUMBIDDERS*2-1:0]          bid_err,
    output logic [NUMBIDDERS*DATAWIDTH-1:0]  balance,
    output logic [NUMBIDDERS-1:0]            win,
    output logic                             ready,
    output logic [2:0]                       err,
    output logic                             roundOver,
    output logic [DATAWIDTH-1:0]             maxBid
);

    localparam int IDXW = (NUMBIDDERS > 1) ? $clog2(NUMBIDDERS) : 1;
    typedef logic [IDXW-1:0] idx_t;

    localparam logic [15:0] AS_WIN = 16'(ANTISNIPE_WINDOW);
`ifdef BIDS_ANTISNIPE_EN
    localparam logic AS_EN = 1'b1;
`else
    localparam logic AS_EN = 1'b0;
`endif

    localparam logic [3:0] OP_NOP       = 4'd0;
    localparam logic [3:0] OP_UNLOCK    = 4'd1;
    localparam logic [3:0] OP_LOCK      = 4'd2;
    localparam logic [3:0] OP_LOADBAL   = 4'd3;
    localparam logic [3:0] OP_SETMASK   = 4'd4;
    localparam logic [3:0] OP_SETTIMER  = 4'd5;
    localparam logic [3:0] OP_SETCHARGE = 4'd6;

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_ROUND    = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NOBIDERROR        = 2'd0,
        ROUNDINACTIVE     = 2'd1,
        INVALIDREQUEST    = 2'd2,
        INSUFFICIENTFUNDS = 2'd3
    } biderrors_t;

    typedef enum logic [2:0] {
        NOERROR            = 3'd0,
        BADKEY             = 3'd1,
        ALREADYUNLOCKED    = 3'd2,
        CSTARTWHENUNLOCKED = 3'd3,
        INVALID_OP         = 3'd4
    } outerrors_t;

    // Zero-extend a bid amount to the balance width.
    function automatic logic [DATAWIDTH-1:0] zext_amt(input logic [BIDAMTBITS-1:0] a);
        logic [DATAWIDTH-1:0] r;
        r = '0;
        r[BIDAMTBITS-1:0] = a;
        return r;
    endfunction

    state_t                  state_q, state_d;
    logic [DATAWIDTH-1:0]    key_q, key_d;
    logic [DATAWIDTH-1:0]    charge_q, charge_d;
    logic [DATAWIDTH-1:0]    max_bid_q, max_bid_d;
    logic [NUMBIDDERS-1:0]   mask_q, mask_d;
    logic [15:0]             timer_cfg_q, timer_cfg_d;
    logic [15:0]             timer_q, timer_d;
    logic [DATAWIDTH-1:0]    bal_q [NUMBIDDERS];
    logic [DATAWIDTH-1:0]    bal_d [NUMBIDDERS];
    logic [BIDAMTBITS-1:0]   lastbid_q [NUMBIDDERS];
    logic [BIDAMTBITS-1:0]   lastbid_d [NUMBIDDERS];
    logic                    lead_vld_q, lead_vld_d;
    idx_t                    lead_idx_q, lead_idx_d;
    logic [NUMBIDDERS-1:0]   ack_q, ack_d;
    logic [NUMBIDDERS-1:0]   win_q, win_d;
    logic [2*NUMBIDDERS-1:0] bid_err_q, bid_err_d;
    outerrors_t              err_q, err_d;
    logic                    ready_q, ready_d;
    logic                    round_over_q, round_over_d;

    logic [BIDAMTBITS-1:0]   amt_s [NUMBIDDERS];
    logic [DATAWIDTH:0]      need_s [NUMBIDDERS];
    logic [NUMBIDDERS-1:0]   ret_ok_s, bid_ok_s;
    logic [BIDAMTBITS-1:0]   relect_val_s, new_val_s;
    idx_t                    relect_idx_s, new_idx_s;
    logic                    lead_ret_s, lead_chg_s, snipe_s;

    // Unpack per-bidder amounts, funds requirement and balance outputs.
    for (genvar g = 0; g < NUMBIDDERS; g++) begin : g_bidder
        assign amt_s[g]  = bid_amt[g*BIDAMTBITS +: BIDAMTBITS];
        // One extra bit so amount + fee cannot wrap before the compare.
        assign need_s[g] = {1'b0, zext_amt(amt_s[g])} + {1'b0, charge_q};
        assign balance[g*DATAWIDTH +: DATAWIDTH] = bal_q[g];
    end

    // Next-state logic: bidder requests, leader tracking, commands, settlement.
    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        charge_d     = charge_q;
        max_bid_d    = max_bid_q;
        mask_d       = mask_q;
        timer_cfg_d  = timer_cfg_q;
        timer_d      = timer_q;
        bal_d        = bal_q;
        lastbid_d    = lastbid_q;
        lead_vld_d   = lead_vld_q;
        lead_idx_d   = lead_idx_q;
        ack_d        = '0;
        win_d        = '0;
        bid_err_d    = '0;
        err_d        = NOERROR;
        round_over_d = 1'b0;
        ret_ok_s     = '0;
        bid_ok_s     = '0;
        relect_val_s = '0;
        relect_idx_s = '0;
        new_val_s    = '0;
        new_idx_s    = '0;
        lead_ret_s   = 1'b0;
        lead_chg_s   = 1'b0;
        snipe_s      = 1'b0;

        // Per-bidder requests; a retract overrides a bid in the same cycle.
        for (int i = 0; i < NUMBIDDERS; i++) begin
            if (retract[i]) begin
                if (state_q != ST_ROUND) begin
                    bid_err_d[2*i +: 2] = ROUNDINACTIVE;
                end else if (!mask_q[i]) begin
                    bid_err_d[2*i +: 2] = INVALIDREQUEST;
                end else begin
                    ack_d[i]     = 1'b1;
                    lastbid_d[i] = '0;
                    ret_ok_s[i]  = 1'b1;
                end
            end else if (bid[i]) begin
                if (state_q != ST_ROUND) begin
                    bid_err_d[2*i +: 2] = ROUNDINACTIVE;
                end else if (!mask_q[i]) begin
                    bid_err_d[2*i +: 2] = INVALIDREQUEST;
                end else if ({1'b0, bal_q[i]} < need_s[i]) begin
                    bid_err_d[2*i +: 2] = INSUFFICIENTFUNDS;
                end else begin
                    ack_d[i]     = 1'b1;
                    bal_d[i]     = bal_q[i] - charge_q;
                    lastbid_d[i] = amt_s[i];
                    bid_ok_s[i]  = 1'b1;
                end
            end else begin
                bid_err_d[2*i +: 2] = NOBIDERROR;
            end
        end

        // Strict '>' scans keep the lowest index on ties and never elect a zero.
        for (int i = 0; i < NUMBIDDERS; i++) begin
            relect_idx_s = (lastbid_d[i] > relect_val_s) ? idx_t'(i) : relect_idx_s;
            relect_val_s = (lastbid_d[i] > relect_val_s) ? lastbid_d[i] : relect_val_s;
            new_idx_s    = (bid_ok_s[i] && (amt_s[i] > new_val_s)) ? idx_t'(i) : new_idx_s;
            new_val_s    = (bid_ok_s[i] && (amt_s[i] > new_val_s)) ? amt_s[i] : new_val_s;
        end
        lead_ret_s = lead_vld_q && ret_ok_s[lead_idx_q];

        case (state_q)
            ST_LOCKED: begin
                if (C_start) begin
                    state_d   = ST_ROUND;
                    timer_d   = (timer_cfg_q == 16'd0) ? 16'd1 : timer_cfg_q;
                    max_bid_d = '0;
                end else begin
                    case (C_op)
                        OP_NOP: err_d = NOERROR;
                        OP_UNLOCK: begin
                            if (C_data == key_q) begin
                                state_d = ST_UNLOCKED;
                            end else begin
                                err_d = BADKEY;
                            end
                        end
                        default: err_d = INVALID_OP;
                    endcase
                end
            end
            ST_UNLOCKED: begin
                if (C_start) begin
                    err_d = CSTARTWHENUNLOCKED;
                end else begin
                    case (C_op)
                        OP_NOP:    err_d = NOERROR;
                        OP_UNLOCK: err_d = ALREADYUNLOCKED;
                        OP_LOCK: begin
                            key_d   = C_data;
                            state_d = ST_LOCKED;
                        end
                        OP_LOADBAL: begin
                            // Top nibble selects the bidder, the rest is the value.
                            if ({1'b0, C_data[DATAWIDTH-1 -: 4]} < 5'(NUMBIDDERS)) begin
                                for (int i = 0; i < NUMBIDDERS; i++) begin
                                    bal_d[i] = (C_data[DATAWIDTH-1 -: 4] == 4'(i))
                                             ? {4'b0000, C_data[DATAWIDTH-5:0]} : bal_d[i];
                                end
                            end else begin
                                err_d = INVALID_OP;
                            end
                        end
                        OP_SETMASK:   mask_d      = C_data[NUMBIDDERS-1:0];
                        OP_SETTIMER:  timer_cfg_d = C_data[15:0];
                        OP_SETCHARGE: charge_d    = C_data;
                        default:      err_d       = INVALID_OP;
                    endcase
                end
            end
            ST_ROUND: begin
                err_d = (C_op != OP_NOP) ? INVALID_OP : NOERROR;
                if (lead_ret_s) begin
                    // Leader withdrew: re-elect from what is still standing.
                    lead_vld_d = (relect_val_s != '0);
                    lead_idx_d = relect_idx_s;
                    max_bid_d  = zext_amt(relect_val_s);
                end else if (zext_amt(new_val_s) > max_bid_q) begin
                    lead_vld_d = 1'b1;
                    lead_idx_d = new_idx_s;
                    max_bid_d  = zext_amt(new_val_s);
                end else begin
                    lead_vld_d = lead_vld_q;
                end
                lead_chg_s = lead_vld_d && (!lead_vld_q || (lead_idx_d != lead_idx_q));
                snipe_s    = AS_EN && lead_chg_s && (timer_q < AS_WIN);
                if (snipe_s) begin
                    timer_d = AS_WIN;
                end else if (timer_q <= 16'd1) begin
                    state_d = ST_SETTLE;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_SETTLE: begin
                err_d        = (C_op != OP_NOP) ? INVALID_OP : NOERROR;
                round_over_d = 1'b1;
                state_d      = ST_LOCKED;
                for (int i = 0; i < NUMBIDDERS; i++) begin
                    win_d[i]     = lead_vld_q && (lead_idx_q == idx_t'(i));
                    bal_d[i]     = (lead_vld_q && (lead_idx_q == idx_t'(i)))
                                 ? (bal_q[i] - zext_amt(lastbid_q[i])) : bal_q[i];
                    lastbid_d[i] = '0;
                end
                lead_vld_d = 1'b0;
                lead_idx_d = '0;
            end
            default: begin
                state_d = ST_LOCKED;
            end
        endcase

        ready_d = (state_d == ST_LOCKED) || (state_d == ST_UNLOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOCKED;
            key_q        <= '0;
            charge_q     <= '0;
            max_bid_q    <= '0;
            mask_q       <= '1;
            timer_cfg_q  <= 16'd0;
            timer_q      <= 16'd0;
            for (int i = 0; i < NUMBIDDERS; i++) begin
                bal_q[i]     <= '0;
                lastbid_q[i] <= '0;
            end
            lead_vld_q   <= 1'b0;
            lead_idx_q   <= '0;
            ack_q        <= '0;
            win_q        <= '0;
            bid_err_q    <= '0;
            err_q        <= NOERROR;
            ready_q      <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            charge_q     <= charge_d;
            max_bid_q    <= max_bid_d;
            mask_q       <= mask_d;
            timer_cfg_q  <= timer_cfg_d;
            timer_q      <= timer_d;
            bal_q        <= bal_d;
            lastbid_q    <= lastbid_d;
            lead_vld_q   <= lead_vld_d;
            lead_idx_q   <= lead_idx_d;
            ack_q        <= ack_d;
            win_q        <= win_d;
            bid_err_q    <= bid_err_d;
            err_q        <= err_d;
            ready_q      <= ready_d;
            round_over_q <= round_over_d;
        end
    end

    assign ack       = ack_q;
    assign bid_err   = bid_err_q;
    assign win       = win_q;
    assign ready     = ready_q;
    assign err       = err_q;
    assign roundOver = round_over_q;
    assign maxBid    = max_bid_q;

endmodule
